// File: rtl/gray_to_rgb_ser.sv
// gray_to_rgb_ser: one-pixel holding register that serializes a grey value into RGB565/666/888 bytes.
// Defining PXL_SER_CNT_EN adds the cnt_clr_i / pxl_cnt_o pixel counter.
module gray_to_rgb_ser #(
  parameter int unsigned GRAY_PXL_W  = 8,
  parameter int unsigned RGB_SPLIT_W = 8,
  parameter int unsigned PXL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [GRAY_PXL_W-1:0]  gray_pxl_dat_i,
  input  logic                   gray_pxl_vld_i,
  output logic                   gray_pxl_rdy_o,
  input  logic [1:0]             fmt_i,
`ifdef PXL_SER_CNT_EN
  input  logic                   cnt_clr_i,
  output logic [PXL_CNT_W-1:0]   pxl_cnt_o,
`endif
  output logic [RGB_SPLIT_W-1:0] rgb_pxl_dat_o,
  output logic                   rgb_pxl_vld_o,
  input  logic                   rgb_pxl_rdy_i,
  output logic                   rgb_pxl_last_o
);

  typedef enum logic [1:0] {
    FMT_RGB565 = 2'd0,
    FMT_RGB666 = 2'd1,
    FMT_RGB888 = 2'd2,
    FMT_RSVD   = 2'd3
  } fmt_e;

  if (GRAY_PXL_W < 8 || GRAY_PXL_W > 16 || RGB_SPLIT_W != 8 || PXL_CNT_W < 1) begin : g_param_chk
    $error("gray_to_rgb_ser: illegal parameter value");
  end

  logic                  full_q, full_d;
  logic [1:0]            idx_q, idx_d;
  logic [GRAY_PXL_W-1:0] gray_q, gray_d;
  fmt_e                  fmt_q, fmt_d;

  logic       in_hs, out_hs, last_hs;
  logic [1:0] last_idx;
  logic [4:0] r5;
  logic [5:0] c6;
  logic [7:0] c8;
  logic [15:0] w565;
  logic [7:0] byte_sel;

  // Channels are MSB truncations of the latched grey value.
  assign c8   = gray_q[GRAY_PXL_W-1 -: 8];
  assign c6   = gray_q[GRAY_PXL_W-1 -: 6];
  assign r5   = gray_q[GRAY_PXL_W-1 -: 5];
  assign w565 = {r5, c6, r5};

  always_comb begin
    last_idx = 2'd1;
    case (fmt_q)
      FMT_RGB666, FMT_RGB888: last_idx = 2'd2;
      default:                last_idx = 2'd1;
    endcase
  end

  always_comb begin
    byte_sel = '0;
    case (fmt_q)
      FMT_RGB666: byte_sel = {c6, 2'b00};
      FMT_RGB888: byte_sel = c8;
      default:    byte_sel = (idx_q == 2'd0) ? w565[15:8] : w565[7:0];
    endcase
  end

  assign rgb_pxl_vld_o  = full_q;
  assign rgb_pxl_dat_o  = full_q ? byte_sel : '0;
  assign rgb_pxl_last_o = full_q & (idx_q == last_idx);
  assign gray_pxl_rdy_o = ~full_q | (rgb_pxl_rdy_i & rgb_pxl_last_o);

  assign in_hs   = gray_pxl_vld_i & gray_pxl_rdy_o;
  assign out_hs  = rgb_pxl_vld_o & rgb_pxl_rdy_i;
  assign last_hs = out_hs & rgb_pxl_last_o;

  // A capture coinciding with the last-byte handshake reloads instead of emptying.
  always_comb begin
    full_d = full_q;
    idx_d  = idx_q;
    gray_d = gray_q;
    fmt_d  = fmt_q;
    if (in_hs) begin
      full_d = 1'b1;
      idx_d  = '0;
      gray_d = gray_pxl_dat_i;
      fmt_d  = fmt_e'(fmt_i);
    end else if (last_hs) begin
      full_d = 1'b0;
      idx_d  = '0;
    end else if (out_hs) begin
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      idx_q  <= '0;
      gray_q <= '0;
      fmt_q  <= FMT_RGB565;
    end else begin
      full_q <= full_d;
      idx_q  <= idx_d;
      gray_q <= gray_d;
      fmt_q  <= fmt_d;
    end
  end

`ifdef PXL_SER_CNT_EN
  logic [PXL_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (last_hs) begin
      cnt_d = cnt_q + PXL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pxl_cnt_o = cnt_q;
`endif

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rgb_pxl_vld_o && !rgb_pxl_rdy_i) |=>
      (rgb_pxl_vld_o && $stable(rgb_pxl_dat_o) && $stable(rgb_pxl_last_o)));

  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
    full_q |-> (idx_q <= last_idx));

endmodule

// File: doc/gray_to_rgb_ser.md
GRAY_TO_RGB_SER -- requirements
Module: gray_to_rgb_ser

Interface
REQ-001 SHALL have parameter GRAY_PXL_W, default 8, input grey width; legal values are 8..16.
REQ-002 SHALL have parameter RGB_SPLIT_W, default 8, output byte width; 8 is the only legal value.
REQ-003 SHALL have parameter PXL_CNT_W, default 16, pixel counter width; used only when PXL_SER_CNT_EN is defined.
REQ-004 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port gray_pxl_dat_i  input  GRAY_PXL_W  grey pixel from the AXI4 FIFO.
REQ-007 SHALL have port gray_pxl_vld_i  input  1  grey pixel valid.
REQ-008 SHALL have port gray_pxl_rdy_o  output  1  grey pixel ready.
REQ-009 SHALL have port fmt_i  input  2  output format: 0=RGB565, 1=RGB666, 2=RGB888, 3=reserved and treated as RGB565.
REQ-010 SHALL have port rgb_pxl_dat_o  output  RGB_SPLIT_W  serialized colour byte to the DBI TX FSM.
REQ-011 SHALL have port rgb_pxl_vld_o  output  1  colour byte valid.
REQ-012 SHALL have port rgb_pxl_rdy_i  input  1  colour byte ready.
REQ-013 SHALL have port rgb_pxl_last_o  output  1  high with the final byte of each pixel.

Function
REQ-014 Input handshake = gray_pxl_vld_i & gray_pxl_rdy_o; output handshake = rgb_pxl_vld_o & rgb_pxl_rdy_i.
REQ-015 On input handshake, SHALL capture the grey value and fmt_i into one holding register and set the full flag.
REQ-016 Channel expansion SHALL use MSB truncation: a W-bit channel = gray[GRAY_PXL_W-1 -: W].
REQ-017 RGB565 SHALL send 2 bytes: byte0 = {r5,g6}[15:8], byte1 = {r5,g6,b5}[7:0].
REQ-018 RGB666 SHALL send 3 bytes, each {c6,2'b00}, in order R, G, B.
REQ-019 RGB888 SHALL send 3 bytes, each c8, in order R, G, B.
REQ-020 A byte index counter SHALL run 0..N-1 (N=2 or 3 from the latched format) and advance only on output handshake.
REQ-021 After the last-byte handshake, the counter SHALL wrap to 0 and full SHALL clear, unless a new pixel is captured in the same cycle.
REQ-022 rgb_pxl_vld_o SHALL equal full; rgb_pxl_dat_o and rgb_pxl_last_o SHALL be driven from the registered state only.
REQ-023 gray_pxl_rdy_o SHALL equal ~full | (rgb_pxl_rdy_i & rgb_pxl_last_o), giving back-to-back pixels with zero bubble cycles.
REQ-024 Latency: the first byte of a pixel SHALL be valid the cycle after its input handshake.
REQ-025 While rgb_pxl_vld_o=1 and rgb_pxl_rdy_i=0, rgb_pxl_dat_o, rgb_pxl_last_o and rgb_pxl_vld_o SHALL hold stable.
REQ-026 Changes to fmt_i while a pixel is in flight SHALL NOT affect that pixel; the new format applies from the next capture.
REQ-027 gray_pxl_dat_i SHALL be sampled only at input handshake; no combinational path from gray_pxl_dat_i to any output is allowed.

Reset
REQ-028 When rst_n is low: full=0, byte index=0, holding register=0, rgb_pxl_vld_o=0, rgb_pxl_dat_o=0, rgb_pxl_last_o=0.
REQ-029 Reset mid-pixel SHALL discard the partial pixel; after reset the next byte out is byte0 of a newly captured pixel.
REQ-030 gray_pxl_rdy_o SHALL be 1 in the first cycle after reset release.

Configuration
REQ-031 With macro PXL_SER_CNT_EN defined, the block SHALL add input cnt_clr_i (1 bit) and output pxl_cnt_o (PXL_CNT_W bits).
REQ-032 pxl_cnt_o SHALL increment by 1 on each last-byte handshake and wrap at 2^PXL_CNT_W.
REQ-033 cnt_clr_i SHALL clear pxl_cnt_o to 0 and take priority over a simultaneous increment.
REQ-034 pxl_cnt_o SHALL reset to 0.
REQ-035 Without PXL_SER_CNT_EN, cnt_clr_i and pxl_cnt_o SHALL not exist and the remaining behaviour SHALL be identical.

Verification
REQ-036 RGB565 case: fmt=0, gray=0xB7, rdy_i=1 -> bytes 0xB5, 0xB6; last=1 on the second byte only.
REQ-037 RGB666 and RGB888 cases: fmt=1, gray=0xB7 -> 0xB4, 0xB4, 0xB4; fmt=2, gray=0xB7 -> 0xB7, 0xB7, 0xB7.
REQ-038 Throughput: 4 consecutive RGB565 pixels with vld_i and rdy_i held high -> 8 bytes on 8 consecutive cycles; gray_pxl_rdy_o pulses on every second cycle.
REQ-039 Backpressure: rdy_i=0 for 5 cycles mid-pixel -> byte held stable, no input accepted, correct order resumes.
REQ-040 Format change: fmt changed 0->2 after the first byte -> current pixel ends after 2 bytes; the next pixel sends 3 bytes.
REQ-041 Reset after byte0 of an RGB888 pixel -> vld_o=0 at once; after release, the next pixel starts at byte0; with PXL_SER_CNT_EN, pxl_cnt_o=0.
